// File: rtl/instr_aligner.sv
// instr_aligner: turns word-aligned 32-bit fetch words into one instruction per handshake.
// Tracks the instruction PC. A redirect flushes the buffered data and loads a new PC.
// Optional feature macro: ALIGNER_RVC_EN enables 16-bit (compressed) instruction support.
// Without ALIGNER_RVC_EN, every fetch word is issued whole as one 32-bit instruction.
// All outputs are decoded from registered state. fetch_ready_o additionally follows
// instr_ready_i when the buffered word is being consumed, which allows zero-bubble streaming.
module instr_aligner #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_is_compressed_o
);

`ifdef ALIGNER_RVC_EN
    typedef enum logic [1:0] {StIdle, StLow, StHigh, StSpan} state_e;
    localparam logic [31:1] PcMask = 31'h7FFF_FFFF;
`else
    typedef enum logic [0:0] {StIdle, StLow} state_e;
    // Halfword PCs do not exist without compressed support.
    localparam logic [31:1] PcMask = 31'h7FFF_FFFE;
`endif

    state_e      state_q;
    logic [31:1] pc_q;
    logic [31:0] wbuf_q;
`ifdef ALIGNER_RVC_EN
    logic [15:0] hbuf_q;
`endif

    logic       accept;
    logic       issue;
    logic       word_done;
    logic [1:0] pc_inc;
    logic       unused_rdpc;

    assign unused_rdpc = redirect_pc_i[0];

    // Decode the presented instruction, its PC step and the fetch handshake from state.
    always_comb begin
        instr_valid_o = 1'b0;
        fetch_ready_o = 1'b0;
        instr_o       = 32'h0;
        word_done     = 1'b0;
        pc_inc        = 2'd0;
        unique case (state_q)
            StIdle: fetch_ready_o = 1'b1;
            StLow: begin
                instr_valid_o = 1'b1;
`ifdef ALIGNER_RVC_EN
                if (wbuf_q[1:0] != 2'b11) begin
                    instr_o = {16'h0, wbuf_q[15:0]};
                    pc_inc  = 2'd1;
                end else begin
                    instr_o   = wbuf_q;
                    pc_inc    = 2'd2;
                    word_done = 1'b1;
                end
`else
                instr_o   = wbuf_q;
                pc_inc    = 2'd2;
                word_done = 1'b1;
`endif
            end
`ifdef ALIGNER_RVC_EN
            StHigh: begin
                if (wbuf_q[17:16] != 2'b11) begin
                    instr_valid_o = 1'b1;
                    instr_o       = {16'h0, wbuf_q[31:16]};
                    pc_inc        = 2'd1;
                    word_done     = 1'b1;
                end else begin
                    // Lower half of a split 32-bit op: wait for the next word.
                    fetch_ready_o = 1'b1;
                end
            end
            StSpan: begin
                instr_valid_o = 1'b1;
                instr_o       = {wbuf_q[15:0], hbuf_q};
                pc_inc        = 2'd2;
            end
`endif
            default: ;
        endcase
        // Refill in the same cycle the last instruction of the word leaves.
        if (word_done) begin
            fetch_ready_o = instr_ready_i;
        end
    end

    assign instr_pc_o = instr_valid_o ? {pc_q, 1'b0} : 32'h0;
`ifdef ALIGNER_RVC_EN
    assign instr_is_compressed_o = instr_valid_o & (instr_o[1:0] != 2'b11);
`else
    assign instr_is_compressed_o = 1'b0;
`endif

    assign accept = fetch_valid_i & fetch_ready_o;
    assign issue  = instr_valid_o & instr_ready_i;

    // State, PC and buffer update; reset beats redirect, redirect beats issue and accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= BOOT_ADDR[31:1] & PcMask;
            wbuf_q  <= 32'h0;
`ifdef ALIGNER_RVC_EN
            hbuf_q  <= 16'h0;
`endif
        end else if (redirect_i) begin
            state_q <= StIdle;
            pc_q    <= redirect_pc_i[31:1] & PcMask;
`ifdef ALIGNER_RVC_EN
            hbuf_q  <= 16'h0;
`endif
        end else begin
            if (issue) begin
                pc_q <= pc_q + {29'd0, pc_inc};
            end
            if (word_done && issue) begin
                if (accept) begin
                    wbuf_q  <= fetch_rdata_i;
                    state_q <= StLow;
                end else begin
                    state_q <= StIdle;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (accept) begin
                            wbuf_q <= fetch_rdata_i;
`ifdef ALIGNER_RVC_EN
                            state_q <= pc_q[1] ? StHigh : StLow;
`else
                            state_q <= StLow;
`endif
                        end
                    end
`ifdef ALIGNER_RVC_EN
                    StLow: begin
                        if (issue) begin
                            state_q <= StHigh;
                        end
                    end
                    StHigh: begin
                        if (accept) begin
                            hbuf_q  <= wbuf_q[31:16];
                            wbuf_q  <= fetch_rdata_i;
                            state_q <= StSpan;
                        end
                    end
                    StSpan: begin
                        if (issue) begin
                            state_q <= StHigh;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_aligner.sv
// Testbench for instr_aligner: directed scenarios plus randomized traffic against a
// halfword-stream reference model with a scoreboard. Honors ALIGNER_RVC_EN like the design.
module tb_instr_aligner;

    localparam logic [31:0] BOOT = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_c;

    always #5 clk = ~clk;

    instr_aligner #(.BOOT_ADDR(BOOT)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .fetch_valid_i         (fetch_valid),
        .fetch_ready_o         (fetch_ready),
        .fetch_rdata_i         (fetch_rdata),
        .redirect_i            (redirect),
        .redirect_pc_i         (redirect_pc),
        .instr_valid_o         (instr_valid),
        .instr_ready_i         (instr_ready),
        .instr_o               (instr),
        .instr_pc_o            (instr_pc),
        .instr_is_compressed_o (instr_c)
    );

    // Instruction memory (1 KiB, address-aliased) that the fetch side streams from.
    logic [31:0] mem [256];
    logic [31:0] faddr;
    logic [31:0] faddr_nxt;
    assign fetch_rdata = mem[faddr[9:2]];
    always @(posedge clk) faddr <= faddr_nxt;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        c;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] hq[$];
    logic [31:0] mpc;
    bit          skip_low;
    int          n_acc = 0;
    int          n_iss = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Restart the model's instruction stream at a new PC.
    task automatic flush(input logic [31:0] pc);
        expq.delete();
        hq.delete();
`ifdef ALIGNER_RVC_EN
        mpc      = {pc[31:1], 1'b0};
        skip_low = pc[1];
`else
        mpc      = {pc[31:2], 2'b00};
        skip_low = 1'b0;
`endif
        faddr_nxt = {pc[31:2], 2'b00};
    endtask

    // Append an accepted fetch word and emit every instruction that is now complete.
    task automatic model_word(input logic [31:0] w);
        exp_t        e;
        logic [15:0] h0;
        bit          more;
`ifdef ALIGNER_RVC_EN
        if (!skip_low) hq.push_back(w[15:0]);
        skip_low = 1'b0;
        hq.push_back(w[31:16]);
        more = 1'b1;
        while (more && hq.size() > 0) begin
            h0 = hq[0];
            if (h0[1:0] != 2'b11) begin
                e.instr = {16'h0, h0};
                e.pc    = mpc;
                e.c     = 1'b1;
                expq.push_back(e);
                void'(hq.pop_front());
                mpc = mpc + 32'd2;
            end else if (hq.size() >= 2) begin
                e.instr = {hq[1], h0};
                e.pc    = mpc;
                e.c     = 1'b0;
                expq.push_back(e);
                void'(hq.pop_front());
                void'(hq.pop_front());
                mpc = mpc + 32'd4;
            end else begin
                more = 1'b0;
            end
        end
`else
        h0      = 16'h0;
        more    = 1'b0;
        e.instr = w;
        e.pc    = mpc;
        e.c     = 1'b0;
        expq.push_back(e);
        mpc = mpc + 32'd4;
`endif
    endtask

    // Monitor: observes each cycle's handshakes mid-cycle and checks against the model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                flush(BOOT);
            end else begin
                chk("valid_vs_model", {31'd0, instr_valid}, (expq.size() != 0) ? 32'd1 : 32'd0);
                if (redirect) begin
                    flush(redirect_pc);
                end else begin
                    if (instr_valid && instr_ready) begin
                        n_iss++;
                        if (expq.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL sb_unexpected: got instr %h pc %h, expected no issue",
                                     instr, instr_pc);
                        end else begin
                            e = expq.pop_front();
                            chk("sb_instr", instr, e.instr);
                            chk("sb_pc", instr_pc, e.pc);
                            chk("sb_is_c", {31'd0, instr_c}, {31'd0, e.c});
                        end
                    end
                    if (fetch_valid && fetch_ready) begin
                        n_acc++;
                        model_word(fetch_rdata);
                        faddr_nxt = faddr + 32'd4;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        tick();
        redirect = 1'b0;
    endtask

    // Present fetch_valid until n more words are accepted (bounded).
    task automatic feed_words(input int n);
        int base;
        int g;
        base = n_acc;
        g    = 0;
        while (n_acc - base < n && g < 50) begin
            fetch_valid = 1'b1;
            tick();
            g++;
        end
        fetch_valid = 1'b0;
        if (n_acc - base < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL feed_timeout: got %0d words accepted, expected %0d", n_acc - base, n);
        end
    endtask

    task automatic fill_random();
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            if ($urandom_range(1) == 1) w[1:0] = 2'b11;
            if ($urandom_range(1) == 1) w[17:16] = 2'b11;
            mem[i] = w;
        end
    endtask

    initial begin
        int base_iss;
        rst         = 1'b1;
        fetch_valid = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        fill_random();
        mem[0] = 32'h0000_0013;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_fetch_ready", {31'd0, fetch_ready}, 32'd1);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);

        // Single 32-bit op; valid exactly one cycle after accept.
        fetch_valid = 1'b1;
        #1;
        chk("t1_valid_at_accept", {31'd0, instr_valid}, 32'd0);
        tick();
        fetch_valid = 1'b0;
        #1;
        chk("t1_valid", {31'd0, instr_valid}, 32'd1);
        chk("t1_instr", instr, 32'h0000_0013);
        chk("t1_pc", instr_pc, 32'h0);
        chk("t1_is_c", {31'd0, instr_c}, 32'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        #1;
        chk("t1_idle", {31'd0, instr_valid}, 32'd0);

        // Two compressed ops in one word.
        mem[0] = 32'h4501_4501;
        do_redirect(32'h0);
        feed_words(1);
        #1;
        chk("t2_instr0", instr, `ifdef ALIGNER_RVC_EN 32'h0000_4501 `else 32'h4501_4501 `endif);
        chk("t2_pc0", instr_pc, 32'h0);
        chk("t2_is_c0", {31'd0, instr_c}, `ifdef ALIGNER_RVC_EN 32'd1 `else 32'd0 `endif);
        instr_ready = 1'b1;
        tick();
`ifdef ALIGNER_RVC_EN
        chk("t2_instr1", instr, 32'h0000_4501);
        chk("t2_pc1", instr_pc, 32'h2);
        chk("t2_is_c1", {31'd0, instr_c}, 32'd1);
        tick();
`endif
        instr_ready = 1'b0;
        #1;
        chk("t2_done_valid", {31'd0, instr_valid}, 32'd0);
        chk("t2_done_ready", {31'd0, fetch_ready}, 32'd1);

        // Compressed, split 32-bit op, compressed.
        mem[0] = 32'h0513_4501;
        mem[1] = 32'h4501_0000;
        do_redirect(32'h0);
        base_iss    = n_iss;
        instr_ready = 1'b1;
        feed_words(2);
        repeat (4) tick();
        instr_ready = 1'b0;
        chk("t3_issues", n_iss - base_iss, `ifdef ALIGNER_RVC_EN 32'd3 `else 32'd2 `endif);
        chk("t3_drained", expq.size(), 32'd0);

        // Downstream stall on a 32-bit op, then issue and refill in one cycle.
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0000_0093;
        do_redirect(32'h0);
        feed_words(1);
        for (int i = 0; i < 3; i++) begin
            fetch_valid = 1'b1;
            #1;
            chk("t4_stall_instr", instr, 32'h0000_0013);
            chk("t4_stall_pc", instr_pc, 32'h0);
            chk("t4_stall_ready", {31'd0, fetch_ready}, 32'd0);
            tick();
        end
        instr_ready = 1'b1;
        #1;
        chk("t4_same_cycle_ready", {31'd0, fetch_ready}, 32'd1);
        tick();
        fetch_valid = 1'b0;
        instr_ready = 1'b0;
        #1;
        chk("t4_next_instr", instr, 32'h0000_0093);
        chk("t4_next_pc", instr_pc, 32'h4);

`ifdef ALIGNER_RVC_EN
        // Redirect while a split op is presented.
        mem[0]  = 32'h0513_4501;
        mem[1]  = 32'h4501_0000;
        mem[64] = 32'h0000_4501;
        do_redirect(32'h0);
        instr_ready = 1'b1;
        feed_words(2);
        #1;
        chk("t5_span_instr", instr, 32'h0000_0513);
        chk("t5_span_pc", instr_pc, 32'h2);
        fetch_valid = 1'b1;
        do_redirect(32'h0000_0102);
        fetch_valid = 1'b0;
        instr_ready = 1'b0;
        #1;
        chk("t5_flushed_valid", {31'd0, instr_valid}, 32'd0);
        feed_words(1);
        #1;
        chk("t5_instr", instr, 32'h0000_0000);
        chk("t5_pc", instr_pc, 32'h0000_0102);
        chk("t5_is_c", {31'd0, instr_c}, 32'd1);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
`endif

        // Reset in the middle of a word.
        mem[0] = 32'h4501_4501;
        do_redirect(32'h0);
        feed_words(1);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_valid", {31'd0, instr_valid}, 32'd0);
        chk("t6_fetch_ready", {31'd0, fetch_ready}, 32'd1);
        chk("t6_instr", instr, 32'h0);
        chk("t6_pc", instr_pc, 32'h0);
        feed_words(1);
        #1;
        chk("t6_refetch_instr", instr, `ifdef ALIGNER_RVC_EN 32'h0000_4501 `else 32'h4501_4501 `endif);
        chk("t6_refetch_pc", instr_pc, BOOT);

        // Randomized traffic, including redirects near the top of the address space.
        fill_random();
        do_redirect(32'h0);
        for (int i = 0; i < 3000; i++) begin
            fetch_valid = ($urandom_range(3) != 0);
            instr_ready = ($urandom_range(3) != 0);
            redirect    = ($urandom_range(24) == 0);
            if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFE0 | ($urandom_range(31) & 32'h1E);
            else redirect_pc = $urandom_range(1023) & 32'hFFFF_FFFE;
            rst = ($urandom_range(400) == 0);
            tick();
        end
        fetch_valid = 1'b0;
        redirect    = 1'b0;
        rst         = 1'b0;
        instr_ready = 1'b1;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
